// File: rtl/rbsp_bit_feeder_pkg.sv
// Shared widths, limits and fill-state encoding for the RBSP bit feeder.
package rbsp_bit_feeder_pkg;

    localparam int unsigned BUF_W    = 64;
    localparam int unsigned WIN_W    = 32;
    localparam int unsigned MAX_FWD  = 32;
    localparam int unsigned FILL_W   = 7;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned FULL_THR = BUF_W - BYTE_W;
    localparam int unsigned RUN_MAX  = 2;
    localparam int unsigned RUN_W    = 2;

    localparam logic [BYTE_W-1:0] EPB_BYTE  = 8'h03;
    localparam logic [BYTE_W-1:0] ZERO_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_FULL  = 2'd2
    } fill_state_e;

endpackage

// File: rtl/rbsp_bit_feeder_epb_filter.sv
// Emulation-prevention filter: tracks the zero-byte run and flags 0x03 bytes to drop.
module rbsp_epb_filter
    import rbsp_bit_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              accept,
    input  logic [BYTE_W-1:0] stream_byte,
    output logic              keep_c
);

    logic [RUN_W-1:0] run_q;

    assign keep_c = !((run_q == RUN_W'(RUN_MAX)) && (stream_byte == EPB_BYTE));

    // Run counter saturates so any longer zero run still arms the drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else if (en && accept) begin
            if (!keep_c) begin
                run_q <= '0;
            end else if (stream_byte == ZERO_BYTE) begin
                run_q <= (run_q == RUN_W'(RUN_MAX)) ? run_q : run_q + RUN_W'(1);
            end else begin
                run_q <= '0;
            end
        end
    end

endmodule

// File: rtl/rbsp_bit_feeder.sv
// Byte-to-bit window feeder with emulation-prevention removal.
// Optional RBSP_BIT_COUNTER_EN adds o_bit_cnt, a running total of forwarded bits.
module rbsp_bit_feeder
    import rbsp_bit_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              i_stream_mem_valid,
    input  logic [BYTE_W-1:0] i_stream_byte,
    output logic              o_stream_byte_ready,
    input  logic              i_forward_en,
    input  logic [LEN_W-1:0]  i_forward_len,
    output logic [WIN_W-1:0]  o_rbsp,
    output logic              o_rbsp_buffer_valid,
    output logic              o_epb_drop,
    output logic              o_forward_err
`ifdef RBSP_BIT_COUNTER_EN
    ,
    output logic [31:0]       o_bit_cnt
`endif
);

    logic [BUF_W-1:0]  buf_q;
    logic [BUF_W-1:0]  buf_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] fill_after;
    fill_state_e       state_q;
    fill_state_e       state_next;
    logic              fwd_ok;
    logic              fwd_bad;
    logic [LEN_W-1:0]  fwd_len;
    logic              accept;
    logic              keep_c;
    logic              valid_q;
    logic              epb_q;
    logic              err_q;

    // Forward requests are only considered once a full window is held.
    assign fwd_ok  = en && i_forward_en && (state_q != ST_EMPTY)
                     && (i_forward_len <= LEN_W'(MAX_FWD));
    assign fwd_bad = en && i_forward_en && (state_q != ST_EMPTY)
                     && (i_forward_len > LEN_W'(MAX_FWD));
    assign fwd_len    = fwd_ok ? i_forward_len : '0;
    assign fill_after = fill_q - FILL_W'(fwd_len);

    assign o_stream_byte_ready = rst_n && en && (fill_after <= FILL_W'(FULL_THR));
    assign accept              = i_stream_mem_valid && o_stream_byte_ready;

    rbsp_epb_filter u_epb_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .accept      (accept),
        .stream_byte (i_stream_byte),
        .keep_c      (keep_c)
    );

    // Bits below fill are always zero, so the new byte can simply be OR-ed in.
    always_comb begin
        buf_next   = buf_q << fwd_len;
        fill_next  = fill_after;
        state_next = state_q;
        if (accept && keep_c) begin
            buf_next  = buf_next | ({i_stream_byte, (BUF_W-BYTE_W)'(0)} >> fill_after);
            fill_next = fill_after + FILL_W'(BYTE_W);
        end
        if (fill_next > FILL_W'(FULL_THR)) begin
            state_next = ST_FULL;
        end else if (fill_next >= FILL_W'(WIN_W)) begin
            state_next = ST_READY;
        end else begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            fill_q  <= '0;
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            epb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            buf_q   <= buf_next;
            fill_q  <= fill_next;
            state_q <= state_next;
            valid_q <= (state_next != ST_EMPTY);
            epb_q   <= accept && !keep_c;
            if (fwd_bad) begin
                err_q <= 1'b1;
            end
        end else begin
            epb_q <= 1'b0;
        end
    end

    assign o_rbsp              = buf_q[BUF_W-1 -: WIN_W];
    assign o_rbsp_buffer_valid = valid_q;
    assign o_epb_drop          = epb_q;
    assign o_forward_err       = err_q;

`ifdef RBSP_BIT_COUNTER_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (fwd_ok) begin
            bit_cnt_q <= bit_cnt_q + 32'(fwd_len);
        end
    end

    assign o_bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_rbsp_bit_feeder.sv
// Scoreboard bench for rbsp_bit_feeder against a bit-queue reference model.
module tb_rbsp_bit_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        i_stream_mem_valid;
    logic [7:0]  i_stream_byte;
    logic        o_stream_byte_ready;
    logic        i_forward_en;
    logic [5:0]  i_forward_len;
    logic [31:0] o_rbsp;
    logic        o_rbsp_buffer_valid;
    logic        o_epb_drop;
    logic        o_forward_err;
`ifdef RBSP_BIT_COUNTER_EN
    logic [31:0] o_bit_cnt;
`endif

    rbsp_bit_feeder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .i_stream_mem_valid  (i_stream_mem_valid),
        .i_stream_byte       (i_stream_byte),
        .o_stream_byte_ready (o_stream_byte_ready),
        .i_forward_en        (i_forward_en),
        .i_forward_len       (i_forward_len),
        .o_rbsp              (o_rbsp),
        .o_rbsp_buffer_valid (o_rbsp_buffer_valid),
        .o_epb_drop          (o_epb_drop),
        .o_forward_err       (o_forward_err)
`ifdef RBSP_BIT_COUNTER_EN
        ,
        .o_bit_cnt           (o_bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rbsp;
        logic        valid;
        logic        epb;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    bit          mq[$];
    int          run_m;
    bit          err_m;
    logic [31:0] cnt_m;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          epb_seen = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] win_m();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) if (i < mq.size()) w[31-i] = mq[i];
        return w;
    endfunction

    // One cycle of stimulus; the model predicts the state after the next rising edge.
    task automatic step(input bit e, input bit v, input logic [7:0] b,
                        input bit fe, input logic [5:0] fl);
        exp_t x;
        int   used;
        bit   vld;
        bit   acc;
        bit   fwd;
        @(negedge clk);
        en = e; i_stream_mem_valid = v; i_stream_byte = b;
        i_forward_en = fe; i_forward_len = fl;
        #1;
        vld  = mq.size() >= 32;
        fwd  = e && fe && vld && (fl <= 32);
        if (e && fe && vld && (fl > 32)) err_m = 1'b1;
        used = fwd ? int'(fl) : 0;
        check("ready", 64'(o_stream_byte_ready), 64'(e && ((mq.size() - used) <= 56)));
        acc = v && e && ((mq.size() - used) <= 56);
        repeat (used) void'(mq.pop_front());
        if (fwd) cnt_m = cnt_m + 32'(used);
        x.epb = 1'b0;
        if (acc) begin
            if (run_m == 2 && b == 8'h03) begin
                run_m = 0;
                x.epb = 1'b1;
            end else begin
                for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
                run_m = (b == 8'h00) ? ((run_m < 2) ? run_m + 1 : 2) : 0;
            end
        end
        x.rbsp  = win_m();
        x.valid = mq.size() >= 32;
        x.err   = err_m;
        x.cnt   = cnt_m;
        sb.push_back(x);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 1'b0, 6'd0);
    endtask

    task automatic feed(input logic [7:0] b);
        step(1'b1, 1'b1, b, 1'b0, 6'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; i_stream_mem_valid = 1'b0;
        i_forward_en = 1'b0; i_forward_len = '0; i_stream_byte = '0;
        #1;
        check("rst_rbsp",  64'(o_rbsp), 64'h0);
        check("rst_valid", 64'(o_rbsp_buffer_valid), 64'h0);
        check("rst_epb",   64'(o_epb_drop), 64'h0);
        check("rst_err",   64'(o_forward_err), 64'h0);
        check("rst_ready", 64'(o_stream_byte_ready), 64'h0);
        mq.delete(); sb.delete();
        run_m = 0; err_m = 1'b0; cnt_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
    endtask

    // Monitor: compare every registered output against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("rbsp",  64'(o_rbsp), 64'(x.rbsp));
                check("valid", 64'(o_rbsp_buffer_valid), 64'(x.valid));
                check("epb",   64'(o_epb_drop), 64'(x.epb));
                check("err",   64'(o_forward_err), 64'(x.err));
`ifdef RBSP_BIT_COUNTER_EN
                check("bit_cnt", 64'(o_bit_cnt), 64'(x.cnt));
`endif
            end
            if (o_epb_drop) epb_seen++;
        end
    end

    initial begin
        int e0;
        logic [7:0] b;
        logic [5:0] fl;
        rst_n = 1'b0; en = 1'b0; i_stream_mem_valid = 1'b0; i_stream_byte = '0;
        i_forward_en = 1'b0; i_forward_len = '0;
        run_m = 0; err_m = 1'b0; cnt_m = '0;

        // Fill from reset
        do_reset();
        feed(8'h12); feed(8'h34); feed(8'h56); feed(8'h78);
        idle();
        check("fill_rbsp",  64'(o_rbsp), 64'h12345678);
        check("fill_valid", 64'(o_rbsp_buffer_valid), 64'h1);

        // Emulation-prevention removal
        do_reset();
        e0 = epb_seen;
        feed(8'h00); feed(8'h00); feed(8'h03); feed(8'h01); feed(8'hAB); feed(8'hCD);
        idle(); idle();
        check("epb_rbsp",  64'(o_rbsp), 64'h000001AB);
        check("epb_count", 64'(epb_seen - e0), 64'h1);

        // Saturated zero run still drops the 0x03
        do_reset();
        e0 = epb_seen;
        feed(8'h00); feed(8'h00); feed(8'h00); feed(8'h03); feed(8'h55);
        idle(); idle();
        check("sat_rbsp",  64'(o_rbsp), 64'h00000055);
        check("sat_count", 64'(epb_seen - e0), 64'h1);

        // Same-cycle forward and append, then illegal forward
        do_reset();
        feed(8'hA1); feed(8'hA2); feed(8'hA3); feed(8'hA4); feed(8'hA5);
        step(1'b1, 1'b1, 8'hB6, 1'b1, 6'd8);
        idle();
        check("fa_rbsp", 64'(o_rbsp), 64'hA2A3A4A5);
        step(1'b1, 1'b0, 8'h00, 1'b1, 6'd40);
        idle();
        check("bad_rbsp", 64'(o_rbsp), 64'hA2A3A4A5);
        check("bad_err",  64'(o_forward_err), 64'h1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 6'd32);
        idle(); idle();
        check("tail_rbsp",  64'(o_rbsp), 64'hB6000000);
        check("err_sticky", 64'(o_forward_err), 64'h1);

        // Backpressure at full, then reset mid-stream
        do_reset();
        for (int i = 1; i <= 8; i++) feed(8'(i * 8'h11));
        idle();
        check("full_ready", 64'(o_stream_byte_ready), 64'h0);
        feed(8'h99);
        idle();
        check("full_rbsp", 64'(o_rbsp), 64'h11223344);
        do_reset();

        // Randomized traffic
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int n = 0; n < 600; n++) begin
                case ($urandom_range(0, 3))
                    0:       b = 8'h00;
                    1:       b = 8'h03;
                    default: b = 8'($urandom);
                endcase
                fl = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(33, 63))
                                                  : 6'($urandom_range(0, 32));
                step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 8, b,
                     $urandom_range(0, 9) < 4, fl);
            end
        end

        idle();
        @(posedge clk);
        #2;
        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
